// File: rtl/amba_axi4_lite_types_pkg.sv
// Shared AXI4-Lite response codes and the address decode used by the slave front-end.
// The decode maps a bus address to a response code and a register index.
package amba_axi4_lite_types_pkg;

  localparam logic [1:0] AXI4_RESP_L_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_L_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_L_DECERR = 2'b11;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] index;
  } axi_decode_t;

  // Offsets are computed one bit wider than any bus address, so BASE_ADDR plus the window size cannot wrap.
  function automatic axi_decode_t axi_decode(input logic [63:0] addr,
                                             input logic [63:0] base_addr,
                                             input int unsigned n_regs,
                                             input int unsigned bytes_per_reg,
                                             input logic        busy);
    axi_decode_t r;
    logic [64:0] off;
    logic [64:0] win;
    logic [64:0] mask;
    off     = {1'b0, addr} - {1'b0, base_addr};
    win     = 65'(n_regs) * 65'(bytes_per_reg);
    mask    = 65'(bytes_per_reg) - 65'd1;
    r.index = 32'((bytes_per_reg == 8) ? (off >> 3) : (off >> 2));
    if ((addr < base_addr) || (off >= win)) begin
      r.resp = AXI4_RESP_L_DECERR;
    end else if ((off & mask) != '0) begin
      r.resp = AXI4_RESP_L_SLVERR;
    end else if (busy) begin
      r.resp = AXI4_RESP_L_SLVERR;
    end else begin
      r.resp = AXI4_RESP_L_OKAY;
    end
    return r;
  endfunction

endpackage

// File: rtl/amba_axi4_lite_slave_gen2_if.sv
// AXI4-Lite bus bundle between a master and the gen2 slave front-end.
interface amba_axi4_lite_slave_gen2_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/amba_axi4_lite_hold_reg.sv
// One-entry holding register: a handshake loads it, the consumer clears it.
module amba_axi4_lite_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);

  // Load only happens while empty and clear only while full, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/amba_axi4_lite_slave_gen2.sv
// AXI4-Lite slave front-end: independent AW/W/AR holds feeding a register bank,
// with range/alignment/busy checks and responses held until the master accepts them.
module amba_axi4_lite_slave_gen2
  import amba_axi4_lite_types_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                N_REGS    = 5,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                IDX_W     = $clog2(N_REGS)
) (
  input  logic                  ACLK,
  input  logic                  ARST,
  amba_axi4_lite_slave_gen2_if.slave bus,
  input  logic                  i_is_busy,
  output logic                  o_en_amba_write,
  output logic [IDX_W-1:0]      o_addr_wc,
  output logic [DATA_W-1:0]     o_data_wc,
  output logic [DATA_W/8-1:0]   o_strb,
  output logic                  o_en_amba_read,
  output logic [IDX_W-1:0]      o_addr_rc,
  input  logic [DATA_W-1:0]     i_data_rc
);

  localparam int SW = DATA_W / 8;

  logic                   aw_full;
  logic [ADDR_W-1:0]      aw_addr;
  logic                   w_full;
  logic [DATA_W+SW-1:0]   w_payload;
  logic                   ar_full;
  logic [ADDR_W-1:0]      ar_addr;

  logic                   w_exec;
  logic                   r_exec;
  logic                   w_ok;
  logic                   r_ok;
  axi_decode_t            wr_dec;
  axi_decode_t            rd_dec;

  logic                   b_valid;
  logic [1:0]             b_resp;
  logic                   r_valid;
  logic [1:0]             r_resp;
  logic [DATA_W-1:0]      r_data;

  logic                   unused_bits;

  amba_axi4_lite_hold_reg #(.W(ADDR_W)) u_aw_hold (
    .clk   (ACLK),
    .rst   (ARST),
    .load  (bus.AWVALID & bus.AWREADY),
    .clear (w_exec),
    .d     (bus.AWADDR),
    .full  (aw_full),
    .q     (aw_addr)
  );

  amba_axi4_lite_hold_reg #(.W(DATA_W + SW)) u_w_hold (
    .clk   (ACLK),
    .rst   (ARST),
    .load  (bus.WVALID & bus.WREADY),
    .clear (w_exec),
    .d     ({bus.WSTRB, bus.WDATA}),
    .full  (w_full),
    .q     (w_payload)
  );

  amba_axi4_lite_hold_reg #(.W(ADDR_W)) u_ar_hold (
    .clk   (ACLK),
    .rst   (ARST),
    .load  (bus.ARVALID & bus.ARREADY),
    .clear (r_exec),
    .d     (bus.ARADDR),
    .full  (ar_full),
    .q     (ar_addr)
  );

  assign bus.AWREADY = ~aw_full & ~ARST;
  assign bus.WREADY  = ~w_full  & ~ARST;
  assign bus.ARREADY = ~ar_full & ~ARST;

  // Busy is sampled in the exec cycle itself, so it feeds the decode combinationally.
  assign wr_dec = axi_decode(64'(aw_addr), 64'(BASE_ADDR), N_REGS, SW, i_is_busy);
  assign rd_dec = axi_decode(64'(ar_addr), 64'(BASE_ADDR), N_REGS, SW, i_is_busy);
  assign w_ok   = (wr_dec.resp == AXI4_RESP_L_OKAY);
  assign r_ok   = (rd_dec.resp == AXI4_RESP_L_OKAY);

  assign w_exec = aw_full & w_full & (~b_valid | bus.BREADY) & ~ARST;
  assign r_exec = ar_full & (~r_valid | bus.RREADY) & ~ARST;

  assign o_en_amba_write = w_exec & w_ok;
  assign o_addr_wc       = o_en_amba_write ? wr_dec.index[IDX_W-1:0] : '0;
  assign o_data_wc       = o_en_amba_write ? w_payload[DATA_W-1:0] : '0;
  assign o_strb          = o_en_amba_write ? w_payload[DATA_W+SW-1:DATA_W] : '0;

  assign o_en_amba_read  = r_exec & r_ok;
  assign o_addr_rc       = o_en_amba_read ? rd_dec.index[IDX_W-1:0] : '0;

  // A new exec may refill the B slot in the same cycle the master accepts the old response.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      b_valid <= 1'b0;
      b_resp  <= AXI4_RESP_L_OKAY;
    end else if (w_exec) begin
      b_valid <= 1'b1;
      b_resp  <= wr_dec.resp;
    end else if (bus.BREADY) begin
      b_valid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_valid <= 1'b0;
      r_resp  <= AXI4_RESP_L_OKAY;
      r_data  <= '0;
    end else if (r_exec) begin
      r_valid <= 1'b1;
      r_resp  <= rd_dec.resp;
      r_data  <= r_ok ? i_data_rc : '0;
    end else if (bus.RREADY) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.BVALID = b_valid;
  assign bus.BRESP  = b_resp;
  assign bus.RVALID = r_valid;
  assign bus.RRESP  = r_resp;
  assign bus.RDATA  = r_data;

  assign unused_bits = ^{wr_dec.index[31:IDX_W], rd_dec.index[31:IDX_W], bus.AWPROT, bus.ARPROT};

endmodule

// File: tb/tb_amba_axi4_lite_slave_gen2.sv
// Directed bench for the gen2 AXI4-Lite slave: a 32-bit instance at base 0 and a 64-bit instance at base 0x100.
module tb_amba_axi4_lite_slave_gen2;

  logic ACLK;
  logic ARST;
  logic i_is_busy;

  int tests_run;
  int tests_failed;

  amba_axi4_lite_slave_gen2_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  amba_axi4_lite_slave_gen2_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  logic        w32_en;
  logic [2:0]  w32_idx;
  logic [31:0] w32_data;
  logic [3:0]  w32_strb;
  logic        r32_en;
  logic [2:0]  r32_idx;
  logic [31:0] r32_din;
  logic [31:0] mem32 [0:7];

  logic        w64_en;
  logic [2:0]  w64_idx;
  logic [63:0] w64_data;
  logic [7:0]  w64_strb;
  logic        r64_en;
  logic [2:0]  r64_idx;
  logic [63:0] r64_din;
  logic [63:0] mem64 [0:7];

  amba_axi4_lite_slave_gen2 #(
    .DATA_W(32), .ADDR_W(32), .N_REGS(5), .BASE_ADDR(32'h0)
  ) dut32 (
    .ACLK            (ACLK),
    .ARST            (ARST),
    .bus             (bus32),
    .i_is_busy       (i_is_busy),
    .o_en_amba_write (w32_en),
    .o_addr_wc       (w32_idx),
    .o_data_wc       (w32_data),
    .o_strb          (w32_strb),
    .o_en_amba_read  (r32_en),
    .o_addr_rc       (r32_idx),
    .i_data_rc       (r32_din)
  );

  amba_axi4_lite_slave_gen2 #(
    .DATA_W(64), .ADDR_W(32), .N_REGS(5), .BASE_ADDR(32'h100)
  ) dut64 (
    .ACLK            (ACLK),
    .ARST            (ARST),
    .bus             (bus64),
    .i_is_busy       (i_is_busy),
    .o_en_amba_write (w64_en),
    .o_addr_wc       (w64_idx),
    .o_data_wc       (w64_data),
    .o_strb          (w64_strb),
    .o_en_amba_read  (r64_en),
    .o_addr_rc       (r64_idx),
    .i_data_rc       (r64_din)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Simple byte-enabled register banks standing in for the adder IP.
  always_ff @(posedge ACLK) begin
    if (w32_en) begin
      for (int b = 0; b < 4; b++)
        if (w32_strb[b]) mem32[w32_idx][8*b +: 8] <= w32_data[8*b +: 8];
    end
    if (w64_en) begin
      for (int b = 0; b < 8; b++)
        if (w64_strb[b]) mem64[w64_idx][8*b +: 8] <= w64_data[8*b +: 8];
    end
  end

  assign r32_din = mem32[r32_idx];
  assign r64_din = mem64[r64_idx];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_write32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus32.AWVALID = 1'b1;
    bus32.AWADDR  = a;
    bus32.WVALID  = 1'b1;
    bus32.WDATA   = d;
    bus32.WSTRB   = s;
  endtask

  task automatic start_read32(input logic [31:0] a);
    bus32.ARVALID = 1'b1;
    bus32.ARADDR  = a;
  endtask

  task automatic drop32();
    bus32.AWVALID = 1'b0;
    bus32.WVALID  = 1'b0;
    bus32.ARVALID = 1'b0;
  endtask

  task automatic start_write64(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bus64.AWVALID = 1'b1;
    bus64.AWADDR  = a;
    bus64.WVALID  = 1'b1;
    bus64.WDATA   = d;
    bus64.WSTRB   = s;
  endtask

  task automatic start_read64(input logic [31:0] a);
    bus64.ARVALID = 1'b1;
    bus64.ARADDR  = a;
  endtask

  task automatic drop64();
    bus64.AWVALID = 1'b0;
    bus64.WVALID  = 1'b0;
    bus64.ARVALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ARST      = 1'b1;
    i_is_busy = 1'b0;
    bus32.AWVALID = 1'b0; bus32.AWADDR = '0; bus32.AWPROT = '0;
    bus32.WVALID  = 1'b0; bus32.WDATA  = '0; bus32.WSTRB  = '0;
    bus32.BREADY  = 1'b1;
    bus32.ARVALID = 1'b0; bus32.ARADDR = '0; bus32.ARPROT = '0;
    bus32.RREADY  = 1'b1;
    bus64.AWVALID = 1'b0; bus64.AWADDR = '0; bus64.AWPROT = '0;
    bus64.WVALID  = 1'b0; bus64.WDATA  = '0; bus64.WSTRB  = '0;
    bus64.BREADY  = 1'b1;
    bus64.ARVALID = 1'b0; bus64.ARADDR = '0; bus64.ARPROT = '0;
    bus64.RREADY  = 1'b1;
    tick();
    tick();

    // Reset state
    check_output("rst_awready", bus32.AWREADY, 0);
    check_output("rst_arready", bus32.ARREADY, 0);
    check_output("rst_bvalid",  bus32.BVALID, 0);
    check_output("rst_rvalid",  bus32.RVALID, 0);
    check_output("rst_rdata",   bus32.RDATA, 0);
    check_output("rst_wr_en",   w32_en, 0);
    ARST = 1'b0;
    #1;
    check_output("post_rst_awready", bus32.AWREADY, 1);
    check_output("post_rst_wready",  bus32.WREADY, 1);

    // AW and W together: strobe at T+1, response at T+2
    start_write32(32'h04, 32'hDEADBEEF, 4'hF);
    tick();
    drop32();
    check_output("t1_wr_en",    w32_en, 1);
    check_output("t1_idx",      w32_idx, 1);
    check_output("t1_data",     w32_data, 32'hDEADBEEF);
    check_output("t1_strb",     w32_strb, 4'hF);
    check_output("t1_awready",  bus32.AWREADY, 0);
    check_output("t1_bvalid_early", bus32.BVALID, 0);
    tick();
    check_output("t1_bvalid",   bus32.BVALID, 1);
    check_output("t1_bresp",    bus32.BRESP, 2'b00);
    check_output("t1_wr_once",  w32_en, 0);
    check_output("t1_idx_idle", w32_idx, 0);
    tick();
    check_output("t1_bclear",   bus32.BVALID, 0);

    // W arrives three cycles ahead of AW
    bus32.WVALID = 1'b1; bus32.WDATA = 32'h12345678; bus32.WSTRB = 4'hF;
    tick();
    bus32.WVALID = 1'b0;
    check_output("t2_wready",   bus32.WREADY, 0);
    check_output("t2_awready",  bus32.AWREADY, 1);
    tick();
    check_output("t2_gap_wr_en", w32_en, 0);
    check_output("t2_awready2", bus32.AWREADY, 1);
    tick();
    bus32.AWVALID = 1'b1; bus32.AWADDR = 32'h10;
    tick();
    bus32.AWVALID = 1'b0;
    check_output("t2_wr_en",    w32_en, 1);
    check_output("t2_idx",      w32_idx, 4);
    check_output("t2_data",     w32_data, 32'h12345678);
    tick();
    check_output("t2_bvalid",   bus32.BVALID, 1);
    check_output("t2_bresp",    bus32.BRESP, 2'b00);
    tick();

    // Preload index 2, then read it under R backpressure
    start_write32(32'h08, 32'hCAFE0001, 4'hF);
    tick();
    drop32();
    tick();
    tick();
    bus32.RREADY = 1'b0;
    start_read32(32'h08);
    tick();
    drop32();
    check_output("t3_rd_en",    r32_en, 1);
    check_output("t3_rd_idx",   r32_idx, 2);
    check_output("t3_arready",  bus32.ARREADY, 0);
    tick();
    check_output("t3_rvalid",   bus32.RVALID, 1);
    check_output("t3_rdata",    bus32.RDATA, 32'hCAFE0001);
    check_output("t3_rresp",    bus32.RRESP, 2'b00);
    start_read32(32'h04);
    tick();
    drop32();
    for (int i = 0; i < 3; i++) begin
      check_output("t3_stall_rvalid",  bus32.RVALID, 1);
      check_output("t3_stall_rdata",   bus32.RDATA, 32'hCAFE0001);
      check_output("t3_stall_arready", bus32.ARREADY, 0);
      check_output("t3_stall_rd_en",   r32_en, 0);
      tick();
    end
    bus32.RREADY = 1'b1;
    #1;
    check_output("t3_rd_en2",   r32_en, 1);
    check_output("t3_rd_idx2",  r32_idx, 1);
    tick();
    check_output("t3_rvalid2",  bus32.RVALID, 1);
    check_output("t3_rdata2",   bus32.RDATA, 32'hDEADBEEF);
    tick();
    check_output("t3_rclear",   bus32.RVALID, 0);

    // Out-of-range write and unaligned read in parallel
    start_write32(32'h14, 32'h0000FFFF, 4'hF);
    start_read32(32'h06);
    tick();
    drop32();
    check_output("t4_wr_en",    w32_en, 0);
    check_output("t4_rd_en",    r32_en, 0);
    check_output("t4_rd_idx",   r32_idx, 0);
    tick();
    check_output("t4_bvalid",   bus32.BVALID, 1);
    check_output("t4_bresp",    bus32.BRESP, 2'b11);
    check_output("t4_rvalid",   bus32.RVALID, 1);
    check_output("t4_rresp",    bus32.RRESP, 2'b10);
    check_output("t4_rdata",    bus32.RDATA, 0);
    tick();

    // Busy during exec rejects, retry succeeds
    i_is_busy = 1'b1;
    start_write32(32'h00, 32'h11111111, 4'hF);
    tick();
    drop32();
    check_output("t5_busy_wr_en", w32_en, 0);
    tick();
    check_output("t5_busy_bresp", bus32.BRESP, 2'b10);
    i_is_busy = 1'b0;
    tick();
    start_write32(32'h00, 32'h11111111, 4'hF);
    tick();
    drop32();
    check_output("t5_retry_en",  w32_en, 1);
    check_output("t5_retry_idx", w32_idx, 0);
    tick();
    check_output("t5_retry_bresp", bus32.BRESP, 2'b00);
    tick();

    // Zero byte mask still pulses the strobe
    start_write32(32'h0C, 32'h0000AAAA, 4'h0);
    tick();
    drop32();
    check_output("zs_wr_en",    w32_en, 1);
    check_output("zs_strb",     w32_strb, 4'h0);
    check_output("zs_data",     w32_data, 32'h0000AAAA);
    tick();
    tick();

    // Same-index read and write in one exec cycle returns the old value
    start_write32(32'h04, 32'h55555555, 4'hF);
    start_read32(32'h04);
    tick();
    drop32();
    check_output("rw_wr_en",    w32_en, 1);
    check_output("rw_rd_en",    r32_en, 1);
    tick();
    check_output("rw_rdata_old", bus32.RDATA, 32'hDEADBEEF);
    tick();
    start_read32(32'h04);
    tick();
    drop32();
    tick();
    check_output("rw_rdata_new", bus32.RDATA, 32'h55555555);
    tick();

    // B backpressure keeps the second write parked
    bus32.BREADY = 1'b0;
    start_write32(32'h00, 32'h00000022, 4'hF);
    tick();
    drop32();
    tick();
    start_write32(32'h04, 32'h00000033, 4'hF);
    tick();
    drop32();
    check_output("bp_awready",  bus32.AWREADY, 0);
    check_output("bp_wready",   bus32.WREADY, 0);
    check_output("bp_wr_en",    w32_en, 0);
    check_output("bp_bvalid",   bus32.BVALID, 1);
    tick();
    check_output("bp_wr_en2",   w32_en, 0);
    bus32.BREADY = 1'b1;
    #1;
    check_output("bp_rel_en",   w32_en, 1);
    check_output("bp_rel_idx",  w32_idx, 1);
    check_output("bp_rel_data", w32_data, 32'h00000033);
    tick();
    check_output("bp_bvalid2",  bus32.BVALID, 1);
    check_output("bp_bresp2",   bus32.BRESP, 2'b00);
    tick();
    check_output("bp_bclear",   bus32.BVALID, 0);

    // Reset with a pending B response and a full AR hold
    bus32.BREADY = 1'b0;
    bus32.RREADY = 1'b0;
    start_write32(32'h10, 32'h00000044, 4'hF);
    start_read32(32'h00);
    tick();
    drop32();
    tick();
    start_read32(32'h04);
    tick();
    drop32();
    check_output("mr_pre_arready", bus32.ARREADY, 0);
    check_output("mr_pre_bvalid",  bus32.BVALID, 1);
    ARST = 1'b1;
    tick();
    check_output("mr_bvalid",   bus32.BVALID, 0);
    check_output("mr_rvalid",   bus32.RVALID, 0);
    check_output("mr_rdata",    bus32.RDATA, 0);
    check_output("mr_awready",  bus32.AWREADY, 0);
    check_output("mr_wready",   bus32.WREADY, 0);
    check_output("mr_arready",  bus32.ARREADY, 0);
    check_output("mr_wr_en",    w32_en, 0);
    check_output("mr_rd_en",    r32_en, 0);
    ARST = 1'b0;
    bus32.BREADY = 1'b1;
    bus32.RREADY = 1'b1;
    #1;
    check_output("mr_arready_free", bus32.ARREADY, 1);
    check_output("mr_no_stale_rd",  r32_en, 0);
    start_write32(32'h10, 32'h00000077, 4'hF);
    tick();
    drop32();
    check_output("mr_wr_en2",   w32_en, 1);
    check_output("mr_idx2",     w32_idx, 4);
    check_output("mr_data2",    w32_data, 32'h00000077);
    tick();
    check_output("mr_bvalid2",  bus32.BVALID, 1);
    check_output("mr_bresp2",   bus32.BRESP, 2'b00);
    tick();

    // 64-bit instance at base 0x100
    start_write64(32'h108, 64'h0123456789ABCDEF, 8'hFF);
    tick();
    drop64();
    check_output("w64_en",      w64_en, 1);
    check_output("w64_idx",     w64_idx, 1);
    check_output("w64_data",    w64_data, 64'h0123456789ABCDEF);
    tick();
    check_output("w64_bresp",   bus64.BRESP, 2'b00);
    tick();
    start_read64(32'h108);
    tick();
    drop64();
    check_output("r64_en",      r64_en, 1);
    check_output("r64_idx",     r64_idx, 1);
    tick();
    check_output("r64_rdata",   bus64.RDATA, 64'h0123456789ABCDEF);
    check_output("r64_rresp",   bus64.RRESP, 2'b00);
    tick();
    start_write64(32'h104, 64'h1, 8'hFF);
    start_read64(32'hF8);
    tick();
    drop64();
    check_output("e64_wr_en",   w64_en, 0);
    check_output("e64_rd_en",   r64_en, 0);
    tick();
    check_output("e64_bresp_unaligned", bus64.BRESP, 2'b10);
    check_output("e64_rresp_below",     bus64.RRESP, 2'b11);
    tick();
    start_write64(32'h120, 64'h5, 8'h0F);
    start_read64(32'h128);
    tick();
    drop64();
    check_output("b64_wr_en",   w64_en, 1);
    check_output("b64_idx",     w64_idx, 4);
    check_output("b64_strb",    w64_strb, 8'h0F);
    check_output("b64_rd_en",   r64_en, 0);
    tick();
    check_output("b64_bresp",   bus64.BRESP, 2'b00);
    check_output("b64_rresp_above", bus64.RRESP, 2'b11);
    check_output("b64_rdata",   bus64.RDATA, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/amba_axi4_lite_slave_gen2.md
Name: amba_axi4_lite_slave_gen2

Overview:
- Parametrised AXI4-Lite slave front-end between the bus and the adder register bank / control module.
- Independent AW, W and AR holding registers accept address and data in any order; write and read channels run fully in parallel.
- Single-beat responses are held until the master accepts them.
- Adds configurable data/address width, register count and base address, an unaligned-access check, DECERR for out-of-range accesses and SLVERR when the IP is busy.

Parameters:
- DATA_W, 32, bus data width in bits; must be 32 or 64.
- ADDR_W, 32, bus address width in bits.
- N_REGS, 5, number of DATA_W-wide registers in the window.
- BASE_ADDR, 0, byte address of register 0; must be aligned to DATA_W/8.
- IDX_W, $clog2(N_REGS), width of the register index presented to the bank.

Ports:
- ACLK in 1: clock, all logic on the rising edge.
- ARST in 1: synchronous, active-high reset.
- AWVALID in 1 / AWREADY out 1 / AWADDR in ADDR_W / AWPROT in 3: write-address channel; AWPROT is ignored.
- WVALID in 1 / WREADY out 1 / WDATA in DATA_W / WSTRB in DATA_W/8: write-data channel.
- BVALID out 1 / BREADY in 1 / BRESP out 2: write-response channel.
- ARVALID in 1 / ARREADY out 1 / ARADDR in ADDR_W / ARPROT in 3: read-address channel; ARPROT is ignored.
- RVALID out 1 / RREADY in 1 / RDATA out DATA_W / RRESP out 2: read-data channel.
- i_is_busy in 1: control module busy; any access executed while it is high is rejected.
- o_en_amba_write out 1: one-cycle register-bank write strobe.
- o_addr_wc out IDX_W / o_data_wc out DATA_W / o_strb out DATA_W/8: write index, data and byte enables; valid only while o_en_amba_write=1, else 0.
- o_en_amba_read out 1 / o_addr_rc out IDX_W: read strobe and index; o_addr_rc is 0 when o_en_amba_read=0.
- i_data_rc in DATA_W: bank read data, combinational from o_addr_rc.

Behaviour:
- Reset: all holding registers are empty and every output is 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, all o_*). Reset mid-transaction drops outstanding holds and responses without completing them.
- Handshakes:
  - AWREADY = aw_hold empty; WREADY = w_hold empty; ARREADY = ar_hold empty.
  - A handshake (VALID&READY) loads the hold register at the clock edge.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
- Address decode:
  - off = ADDR - BASE_ADDR.
  - DECERR (2'b11) if ADDR < BASE_ADDR or off >= N_REGS*DATA_W/8.
  - Otherwise SLVERR (2'b10) if off is not a multiple of DATA_W/8.
  - Otherwise SLVERR if i_is_busy=1 in the exec cycle.
  - Otherwise OKAY (2'b00); index = off / (DATA_W/8).
- Write exec cycle: aw_hold and w_hold are both full, and the B slot is free (BVALID=0 or BREADY=1).
  - If decode is OK: o_en_amba_write=1 for exactly one cycle with index, WDATA and WSTRB driven. WSTRB=0 still pulses the strobe with a zero mask.
  - Both holds clear at the end of the exec cycle.
  - BVALID/BRESP are registered and rise the next cycle; they hold stable until BREADY.
  - Latency: AW+W handshake at T -> exec T+1 -> BVALID T+2; minimum AW-to-AW spacing is 2 cycles.
- Read exec cycle: ar_hold is full and the R slot is free (RVALID=0 or RREADY=1).
  - If decode is OK: o_en_amba_read=1 and o_addr_rc=index; i_data_rc is captured into RDATA at the end of the cycle.
  - On error: no read strobe and RDATA=0.
  - RVALID rises the next cycle; RDATA/RRESP hold stable until RREADY.
  - Latency: AR handshake T -> RVALID T+2.
- Backpressure: with BREADY=0 the W/AW holds stay full and AWREADY/WREADY stay low; no write strobe fires and nothing is lost. The R channel behaves the same way.
- Simultaneous read and write exec to the same index in one cycle: the read returns the pre-write value.
- Width rule: offset arithmetic is done in ADDR_W+1 bits so BASE_ADDR + window size cannot wrap.

Decomposition:
- Extend amba_axi4_lite_types_pkg with AXI4_RESP_L_DECERR (2'b11), alongside the existing OKAY and SLVERR codes.
- Add a shared decode function to the package: addr -> {resp, index}, parametrised through module parameters.
- One natural sub-module, amba_axi4_lite_hold_reg: a one-entry valid/payload register with a load/clear handshake, instantiated for AW, W and AR.

Test Plan:
- AW 0x04 and W 0xDEADBEEF / STRB 4'hF in the same cycle, BREADY=1 -> o_en_amba_write pulses once at T+1 with index 1 and data 0xDEADBEEF; BVALID at T+2 with BRESP=OKAY.
- W data 0x12345678 presented 3 cycles before AW 0x10 -> single write to index 4 with data 0x12345678, BRESP=OKAY; AWREADY stays high while WREADY is low during the gap.
- AR 0x08 with i_data_rc=0xCAFE0001 at index 2, RREADY held low for 4 cycles -> RVALID held with RDATA=0xCAFE0001 and RRESP=OKAY throughout, ARREADY=0 while the AR hold is full; a second AR is accepted after RREADY rises.
- AW 0x14 (N_REGS=5) -> no write strobe, BRESP=DECERR. AR 0x06 -> no read strobe, RRESP=SLVERR, RDATA=0.
- i_is_busy=1 during the write exec cycle for AW 0x00 -> no strobe, BRESP=SLVERR; i_is_busy=0 on the retry -> OKAY with the strobe.
- ARST asserted while BVALID=1 and ar_hold is full -> next cycle all VALIDs and o_* are 0 and all READYs are 0; the first post-reset write then completes normally. Repeat the suite with DATA_W=64, BASE_ADDR=0x100.
